fir_stream_param: RTL and testbench

- Parametrised successor to the fixed 11-tap stream FIR in the user ASIC area.
- Loads NUM_TAPS signed coefficients, then a frame of up to cfg_len samples, from one AXI-stream slave.
- Produces one filtered sample per input on an AXI-stream master that honours backpressure. Feeds the output FIFO path.
- Uses one shared multiplier (one tap per cycle) instead of 11 parallel multipliers.

---
 rtl/fir_pkg.sv | 30 +++
 rtl/fir_mac.sv | 75 +++++++
 rtl/fir_stream_param.sv | 194 +++++++++++++++++++
 tb/tb_fir_stream_param.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the parametrised streaming FIR (fir_stream_param)
// and its multiply-accumulate unit (fir_mac).
//   - state_t       : controller states
//   - acc_w()       : accumulator width for a given word width and tap count
//   - DEFAULT_*     : default parameter values for the FIR slice
// ---------------------------------------------------------------------------
package fir_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_TAPS = 11;
  localparam int DEFAULT_LEN_W    = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    MAC,
    OUT,
    DONE
  } state_t;

  // A full-width signed product needs 2*data_w bits. Summing num_taps such
  // products can grow by up to clog2(num_taps) more bits.
  function automatic int acc_w(input int data_w, input int num_taps);
    return 2 * data_w + $clog2(num_taps);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// ---------------------------------------------------------------------------
// fir_mac
// Signed multiply-accumulate unit shared by all taps of the FIR, plus the
// output stage that narrows the accumulator to one DATA_W word.
//
// Build option: define FIR_SAT_EN to clamp an out-of-range accumulator to
// the nearest signed DATA_W bound; otherwise the low DATA_W bits are
// returned (wrap).
//
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset, clears the accumulator
//   clr     in   clear accumulator (start of a new output sample)
//   en      in   accumulate coef*sample this cycle
//   coef    in   DATA_W signed coefficient
//   sample  in   DATA_W signed history sample
//   result  out  DATA_W filter output derived from the accumulator
// ---------------------------------------------------------------------------
module fir_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ACC_W  = acc_w(DEFAULT_DATA_W, DEFAULT_NUM_TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] coef,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] result
);

  logic signed [2*DATA_W-1:0] coef_ext;
  logic signed [2*DATA_W-1:0] sample_ext;
  logic signed [2*DATA_W-1:0] product;
  logic signed [ACC_W-1:0]    product_ext;
  logic signed [ACC_W-1:0]    acc;

  // Sign-extend both operands to the product width so the multiply yields
  // the exact 2*DATA_W-bit signed product.
  assign coef_ext    = {{DATA_W{coef[DATA_W-1]}}, coef};
  assign sample_ext  = {{DATA_W{sample[DATA_W-1]}}, sample};
  assign product     = coef_ext * sample_ext;
  assign product_ext = {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + product_ext;
    end
  end

`ifdef FIR_SAT_EN
  logic [ACC_W-DATA_W:0] acc_hi;

  // The accumulator fits in DATA_W signed bits exactly when every bit from
  // the top down to bit DATA_W-1 agrees; otherwise clamp by the sign.
  assign acc_hi = acc[ACC_W-1:DATA_W-1];

  always_comb begin
    result = acc[DATA_W-1:0];
    if (!((&acc_hi) || !(|acc_hi))) begin
      result = acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                            : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  assign result = acc[DATA_W-1:0];
`endif

endmodule

// File: rtl/fir_stream_param.sv
// ---------------------------------------------------------------------------
// fir_stream_param
// Parametrised streaming FIR filter with a single shared multiplier.
// One AXI-stream slave delivers NUM_TAPS coefficients followed by a frame
// of up to cfg_len samples; each sample produces one filtered output on an
// AXI-stream master that honours backpressure. Each output takes NUM_TAPS
// MAC cycles, one tap per cycle.
//
// Build option: FIR_SAT_EN (see fir_mac) selects saturating output instead
// of wrap-around.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   ap_start   in   start pulse, accepted only in IDLE
//   cfg_len    in   samples per frame, captured with ap_start
//   ss_tvalid  in   input stream valid
//   ss_tdata   in   coefficient or sample word
//   ss_tlast   in   early end-of-frame marker on a sample
//   ss_tready  out  input stream ready (registered)
//   sm_tvalid  out  output stream valid (registered)
//   sm_tdata   out  filter output
//   sm_tlast   out  last output of the frame
//   sm_tready  in   downstream ready
//   busy       out  high whenever the controller is not IDLE
//   done       out  one-cycle pulse when the frame completes
// ---------------------------------------------------------------------------
module fir_stream_param
  import fir_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_TAPS = DEFAULT_NUM_TAPS,
  parameter int LEN_W    = DEFAULT_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ap_start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              ss_tvalid,
  input  logic [DATA_W-1:0] ss_tdata,
  input  logic              ss_tlast,
  output logic              ss_tready,
  output logic              sm_tvalid,
  output logic [DATA_W-1:0] sm_tdata,
  output logic              sm_tlast,
  input  logic              sm_tready,
  output logic              busy,
  output logic              done
);

  localparam int ACC_W = acc_w(DATA_W, NUM_TAPS);
  localparam int IDX_W = $clog2(NUM_TAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

  state_t state;
  state_t next_state;

  logic [DATA_W-1:0] taps [NUM_TAPS];
  logic [DATA_W-1:0] hist [NUM_TAPS];

  logic [IDX_W-1:0] tap_idx;
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_ptr;
  logic [IDX_W-1:0] mac_j;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] count;
  logic             tlast_seen;

  logic             ss_hs;
  logic             mac_clr;
  logic             mac_en;
  logic [DATA_W-1:0] mac_result;

  assign ss_hs   = ss_tvalid & ss_tready;
  assign mac_clr = (state == WAIT) & ss_hs;
  assign mac_en  = (state == MAC);

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign sm_tdata = mac_result;
  assign sm_tlast = sm_tvalid & tlast_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (ap_start) next_state = LOAD;
      end
      LOAD: begin
        if (ss_hs && (tap_idx == LAST_IDX)) begin
          next_state = (len_reg == '0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (ss_hs) next_state = MAC;
      end
      MAC: begin
        if (mac_j == LAST_IDX) next_state = OUT;
      end
      OUT: begin
        if (sm_tready) next_state = tlast_seen ? DONE : WAIT;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Handshake flags are registered from next_state so they are already
  // valid on the first cycle of the state that owns them.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_tready  <= 1'b0;
      sm_tvalid  <= 1'b0;
      tap_idx    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mac_j      <= '0;
      len_reg    <= '0;
      count      <= '0;
      tlast_seen <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        taps[i] <= '0;
        hist[i] <= '0;
      end
    end else begin
      ss_tready <= (next_state == LOAD) || (next_state == WAIT);
      sm_tvalid <= (next_state == OUT);
      case (state)
        IDLE: begin
          if (ap_start) begin
            len_reg    <= cfg_len;
            tap_idx    <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            tlast_seen <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
              hist[i] <= '0;
            end
          end
        end
        LOAD: begin
          if (ss_hs) begin
            taps[tap_idx] <= ss_tdata;
            if (tap_idx != LAST_IDX) tap_idx <= tap_idx + IDX_W'(1);
          end
        end
        WAIT: begin
          // rd_ptr starts at the newest sample and walks backwards in
          // time, so tap j always meets x[n-j].
          if (ss_hs) begin
            hist[wr_ptr] <= ss_tdata;
            rd_ptr       <= wr_ptr;
            wr_ptr       <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + IDX_W'(1);
            tlast_seen   <= ss_tlast | (count == len_reg - LEN_W'(1));
            count        <= count + LEN_W'(1);
            mac_j        <= '0;
          end
        end
        MAC: begin
          mac_j  <= mac_j + IDX_W'(1);
          rd_ptr <= (rd_ptr == '0) ? LAST_IDX : rd_ptr - IDX_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  fir_mac #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr   (mac_clr),
    .en    (mac_en),
    .coef  (taps[mac_j]),
    .sample(hist[rd_ptr]),
    .result(mac_result)
  );

endmodule

// File: tb/tb_fir_stream_param.sv
// ---------------------------------------------------------------------------
// tb_fir_stream_param
// Self-checking bench for fir_stream_param. Outputs are compared with a
// direct-form convolution model y[n] = sum tap[j]*x[n-j] held in the bench.
// Honours FIR_SAT_EN the same way as the design build.
// ---------------------------------------------------------------------------
module tb_fir_stream_param;

  localparam int DW = 32;
  localparam int NT = 11;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ap_start = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic          ss_tvalid = 1'b0;
  logic [DW-1:0] ss_tdata = '0;
  logic          ss_tlast = 1'b0;
  logic          ss_tready;
  logic          sm_tvalid;
  logic [DW-1:0] sm_tdata;
  logic          sm_tlast;
  logic          sm_tready = 1'b1;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic signed [DW-1:0] model_taps [NT];
  logic signed [DW-1:0] model_x [$];

  always #5 clk = ~clk;

  fir_stream_param #(.DATA_W(DW), .NUM_TAPS(NT), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .ap_start(ap_start), .cfg_len(cfg_len),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
    .ss_tready(ss_tready), .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata),
    .sm_tlast(sm_tlast), .sm_tready(sm_tready), .busy(busy), .done(done)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, got hang expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: full-precision convolution over the samples seen so far,
  // with samples before the frame start taken as zero.
  function automatic logic [DW-1:0] model_y(input int n);
    logic signed [127:0] acc;
    longint              p;
    acc = '0;
    for (int j = 0; j < NT; j++) begin
      if (n - j >= 0) begin
        p   = longint'(model_taps[j]) * longint'(model_x[n-j]);
        acc = acc + p;
      end
    end
`ifdef FIR_SAT_EN
    if (acc > 128'sd2147483647) return 32'h7FFFFFFF;
    if (acc < -128'sd2147483648) return 32'h80000000;
`endif
    return acc[DW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int len);
    cfg_len  = LW'(len);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic last, output bit ok);
    ok        = 1'b0;
    ss_tvalid = 1'b1;
    ss_tdata  = d;
    ss_tlast  = last;
    for (int c = 0; c < 100; c++) begin
      if (ss_tready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    ss_tvalid = 1'b0;
    ss_tlast  = 1'b0;
  endtask

  task automatic recv_word(output logic [DW-1:0] d, output logic l, output bit ok);
    ok = 1'b0;
    d  = '0;
    l  = 1'b0;
    sm_tready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (sm_tvalid) begin
        d = sm_tdata;
        l = sm_tlast;
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // ss_tlast is driven randomly while loading taps; the design must ignore it.
  task automatic load_taps(output bit ok);
    bit ok_j;
    ok = 1'b1;
    for (int j = 0; j < NT; j++) begin
      send_word(model_taps[j], 1'($urandom), ok_j);
      if (!ok_j) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++; if (sm_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_sm_tvalid: got %0b expected 0", sm_tvalid); end
    checks++; if (sm_tdata !== '0) begin errors++; $display("[TB] FAIL reset_sm_tdata: got %h expected 0", sm_tdata); end
    checks++; if (sm_tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_sm_tlast: got %0b expected 0", sm_tlast); end
    checks++; if (ss_tready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ss_tready: got %0b expected 0", ss_tready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_impulse(input string tag);
    logic [DW-1:0] d;
    logic          l;
    bit            ok;
    for (int j = 0; j < NT; j++) model_taps[j] = DW'(j + 1);
    model_x.delete();
    model_x.push_back(1);
    repeat (12) model_x.push_back(0);
    start_frame(13);
    load_taps(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL %s_load: got timeout expected handshakes", tag); end
    for (int n = 0; n < 13; n++) begin
      send_word(model_x[n], 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL %s_send n=%0d: got timeout expected handshake", tag, n); end
      recv_word(d, l, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL %s_recv n=%0d: got timeout expected output", tag, n); end
      checks++; if (d !== model_y(n)) begin errors++; $display("[TB] FAIL %s_data n=%0d: got %h expected %h", tag, n, d, model_y(n)); end
      checks++; if (l !== (n == 12)) begin errors++; $display("[TB] FAIL %s_tlast n=%0d: got %0b expected %0b", tag, n, l, (n == 12)); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL %s_done: got %0b expected 1", tag, done); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL %s_done_pulse: got %0b expected 0", tag, done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL %s_busy: got %0b expected 0", tag, busy); end
  endtask

  task automatic test_moving_sum();
    logic [DW-1:0] d;
    logic          l;
    bit            ok;
    int            lat;
    for (int j = 0; j < NT; j++) model_taps[j] = 1;
    model_x.delete();
    for (int n = 0; n < 15; n++) model_x.push_back(DW'(n + 1));
    start_frame(15);
    load_taps(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL msum_load: got timeout expected handshakes"); end
    for (int n = 0; n < 15; n++) begin
      send_word(model_x[n], 1'b0, ok);
      lat = 0;
      while (!sm_tvalid && lat < 100) begin
        tick();
        lat++;
      end
      checks++; if (lat != NT) begin errors++; $display("[TB] FAIL msum_latency n=%0d: got %0d expected %0d", n, lat, NT); end
      recv_word(d, l, ok);
      checks++; if (d !== model_y(n)) begin errors++; $display("[TB] FAIL msum_data n=%0d: got %0d expected %0d", n, d, model_y(n)); end
      checks++; if (l !== (n == 14)) begin errors++; $display("[TB] FAIL msum_tlast n=%0d: got %0b expected %0b", n, l, (n == 14)); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL msum_done: got %0b expected 1", done); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d;
    logic [DW-1:0] exp_d;
    logic          l;
    bit            ok;
    int            w;
    for (int j = 0; j < NT; j++) model_taps[j] = $urandom;
    model_x.delete();
    for (int n = 0; n < 5; n++) model_x.push_back($urandom);
    start_frame(5);
    load_taps(ok);
    for (int n = 0; n < 5; n++) begin
      send_word(model_x[n], 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_send n=%0d: got timeout expected handshake", n); end
      sm_tready = 1'b0;
      w = 0;
      while (!sm_tvalid && w < 100) begin
        tick();
        w++;
      end
      exp_d = model_y(n);
      if (n < 4) begin
        ss_tvalid = 1'b1;
        ss_tdata  = model_x[n+1];
      end
      for (int s = 0; s < 5; s++) begin
        checks++; if (sm_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid n=%0d s=%0d: got %0b expected 1", n, s, sm_tvalid); end
        checks++; if (sm_tdata !== exp_d) begin errors++; $display("[TB] FAIL bp_stable n=%0d s=%0d: got %h expected %h", n, s, sm_tdata, exp_d); end
        checks++; if (sm_tlast !== (n == 4)) begin errors++; $display("[TB] FAIL bp_tlast n=%0d s=%0d: got %0b expected %0b", n, s, sm_tlast, (n == 4)); end
        checks++; if (ss_tready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ss_tready n=%0d s=%0d: got %0b expected 0", n, s, ss_tready); end
        tick();
      end
      ss_tvalid = 1'b0;
      recv_word(d, l, ok);
      checks++; if (d !== exp_d) begin errors++; $display("[TB] FAIL bp_data n=%0d: got %h expected %h", n, d, exp_d); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL bp_done: got %0b expected 1", done); end
    tick();
  endtask

  task automatic test_early_tlast();
    logic [DW-1:0] d;
    logic          l;
    bit            ok;
    for (int j = 0; j < NT; j++) model_taps[j] = $urandom;
    model_x.delete();
    for (int n = 0; n < 4; n++) model_x.push_back($urandom);
    start_frame(20);
    load_taps(ok);
    for (int n = 0; n < 4; n++) begin
      send_word(model_x[n], (n == 3), ok);
      recv_word(d, l, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL early_recv n=%0d: got timeout expected output", n); end
      checks++; if (d !== model_y(n)) begin errors++; $display("[TB] FAIL early_data n=%0d: got %h expected %h", n, d, model_y(n)); end
      checks++; if (l !== (n == 3)) begin errors++; $display("[TB] FAIL early_tlast n=%0d: got %0b expected %0b", n, l, (n == 3)); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL early_done: got %0b expected 1", done); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL early_busy: got %0b expected 0", busy); end
    checks++; if (ss_tready !== 1'b0) begin errors++; $display("[TB] FAIL early_ss_tready: got %0b expected 0", ss_tready); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] d;
    logic [DW-1:0] exp2;
    logic          l;
    bit            ok;
`ifdef FIR_SAT_EN
    exp2 = 32'h7FFFFFFF;
`else
    exp2 = 32'h00000002;
`endif
    for (int j = 0; j < NT; j++) model_taps[j] = (j < 2) ? 32'h7FFFFFFF : 32'h0;
    model_x.delete();
    model_x.push_back(32'h7FFFFFFF);
    model_x.push_back(32'h7FFFFFFF);
    start_frame(2);
    load_taps(ok);
    for (int n = 0; n < 2; n++) begin
      send_word(model_x[n], 1'b0, ok);
      recv_word(d, l, ok);
      checks++; if (d !== model_y(n)) begin errors++; $display("[TB] FAIL ovf_data n=%0d: got %h expected %h", n, d, model_y(n)); end
      checks++; if (l !== (n == 1)) begin errors++; $display("[TB] FAIL ovf_tlast n=%0d: got %0b expected %0b", n, l, (n == 1)); end
      if (n == 1) begin
        checks++; if (d !== exp2) begin errors++; $display("[TB] FAIL ovf_second: got %h expected %h", d, exp2); end
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL ovf_done: got %0b expected 1", done); end
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    for (int j = 0; j < NT; j++) model_taps[j] = DW'(j + 1);
    start_frame(13);
    load_taps(ok);
    send_word(32'd1, 1'b0, ok);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (sm_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_sm_tvalid: got %0b expected 0", sm_tvalid); end
    checks++; if (sm_tdata !== '0) begin errors++; $display("[TB] FAIL midrst_sm_tdata: got %h expected 0", sm_tdata); end
    checks++; if (sm_tlast !== 1'b0) begin errors++; $display("[TB] FAIL midrst_sm_tlast: got %0b expected 0", sm_tlast); end
    checks++; if (ss_tready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ss_tready: got %0b expected 0", ss_tready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done: got %0b expected 0", done); end
    tick();
  endtask

  task automatic test_zero_len();
    bit ok;
    for (int j = 0; j < NT; j++) model_taps[j] = $urandom;
    start_frame(0);
    load_taps(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL zlen_load: got timeout expected handshakes"); end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL zlen_done: got %0b expected 1", done); end
    checks++; if (sm_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL zlen_sm_tvalid: got %0b expected 0", sm_tvalid); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zlen_busy: got %0b expected 0", busy); end
  endtask

  // Random frames with random length, optional early tlast, and a stray
  // ap_start pulse mid-frame that must be ignored.
  task automatic test_random();
    logic [DW-1:0] d;
    logic          l;
    bit            ok;
    int            len;
    int            tl;
    int            nout;
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < NT; j++) model_taps[j] = $urandom;
      len  = $urandom_range(1, 14);
      tl   = $urandom_range(0, len);
      nout = (tl < len) ? tl + 1 : len;
      model_x.delete();
      for (int n = 0; n < nout; n++) model_x.push_back($urandom);
      start_frame(len);
      load_taps(ok);
      for (int n = 0; n < nout; n++) begin
        if (n == 1) begin
          cfg_len  = 1;
          ap_start = 1'b1;
          tick();
          ap_start = 1'b0;
        end
        send_word(model_x[n], (n == tl), ok);
        recv_word(d, l, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rnd_recv f=%0d n=%0d: got timeout expected output", f, n); end
        checks++; if (d !== model_y(n)) begin errors++; $display("[TB] FAIL rnd_data f=%0d n=%0d: got %h expected %h", f, n, d, model_y(n)); end
        checks++; if (l !== (n == nout - 1)) begin errors++; $display("[TB] FAIL rnd_tlast f=%0d n=%0d: got %0b expected %0b", f, n, l, (n == nout - 1)); end
      end
      checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL rnd_done f=%0d: got %0b expected 1", f, done); end
      tick();
    end
  endtask

  initial begin
    repeat (3) tick();
    test_reset();
    test_impulse("impulse");
    test_moving_sum();
    test_backpressure();
    test_early_tlast();
    test_overflow();
    test_reset_mid();
    test_impulse("impulse_after_reset");
    test_zero_len();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
